pc_next_unit: RTL and testbench

//   Program-counter register and next-PC selection for the pipelined MIPS datapath. Consumes the
//   28-bit word-shifted jump field from the jump-address shifter and forms the 32-bit jump target

---
 rtl/mips_pkg.sv | 30 +++
 rtl/pc_target_mux.sv | 57 +++++
 rtl/pc_next_unit.sv | 134 +++++++++++++
 tb/tb_pc_next_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_pkg                                                     |
// | Description : Shared widths, reset PC, fetch-select and PC FSM encodings.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_pkg;

   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      PCSEL_SEQ = 2'd0,
      PCSEL_BR  = 2'd1,
      PCSEL_J   = 2'd2,
      PCSEL_JR  = 2'd3
   } pcsel_e;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Instruction fetch is word addressed; low address bits are always dropped.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_target_mux                                                |
// | Description : Priority select (jr > jump > branch) and redirect target     |
// |               formation with word-alignment check. Purely combinational.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_target_mux
   import mips_pkg::*;
(
   input  logic              jr_i,
   input  logic              jump_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] redirect_base_i,
   input  logic [27:0]       jump_shift_i,
   input  logic [ADDR_W-1:0] branch_off_i,
   input  logic [ADDR_W-1:0] jr_addr_i,
   output logic [ADDR_W-1:0] target_o,
   output logic              valid_o,
   output logic              misalign_o
);

   pcsel_e              w_sel;
   logic [ADDR_W-1:0]   w_raw;
   logic [ADDR_W-1:0]   w_jump_tgt;
   logic [ADDR_W-1:0]   w_branch_tgt;

   assign w_jump_tgt   = {redirect_base_i[ADDR_W-1:28], jump_shift_i};
   // Carry out of the branch add is deliberately discarded (modulo 2^32).
   assign w_branch_tgt = redirect_base_i + branch_off_i;

   always_comb begin
      w_sel = PCSEL_SEQ;
      if (jr_i)
         w_sel = PCSEL_JR;
      else if (jump_i)
         w_sel = PCSEL_J;
      else if (branch_taken_i)
         w_sel = PCSEL_BR;
   end

   always_comb begin
      w_raw = redirect_base_i;
      case (w_sel)
         PCSEL_JR: w_raw = jr_addr_i;
         PCSEL_J:  w_raw = w_jump_tgt;
         PCSEL_BR: w_raw = w_branch_tgt;
         default:  w_raw = redirect_base_i;
      endcase
   end

   assign valid_o    = (w_sel != PCSEL_SEQ);
   assign misalign_o = valid_o && (w_raw[1:0] != 2'b00);
   assign target_o   = word_align(w_raw);

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_next_unit                                                 |
// | Description : PC register, next-PC arbitration, stall-time redirect hold,  |
// |               IF/ID flush pulse, sticky misalign flag, redirect counter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_next_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int                CNT_W    = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              stall_i,
   input  logic              jr_i,
   input  logic              jump_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] redirect_base_i,
   input  logic [27:0]       jump_shift_i,
   input  logic [ADDR_W-1:0] branch_off_i,
   input  logic [ADDR_W-1:0] jr_addr_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic              flush_o,
   output logic              misalign_o,
   output logic [CNT_W-1:0]  redirect_cnt_o
);

   localparam logic [ADDR_W-1:0] c_pc_step = 32'd4;
   localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
   localparam logic [CNT_W-1:0]  c_cnt_max = '1;

   state_e              r_state;
   state_e              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_next;
   logic [ADDR_W-1:0]   r_pend;
   logic [ADDR_W-1:0]   w_pend_next;
   logic                r_flush;
   logic                w_flush_next;
   logic                r_misalign;
   logic                w_misalign_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_cnt_inc;

   logic [ADDR_W-1:0]   w_target;
   logic                w_valid;
   logic                w_misalign;

   pc_target_mux u_target_mux (
      .jr_i            (jr_i),
      .jump_i          (jump_i),
      .branch_taken_i  (branch_taken_i),
      .redirect_base_i (redirect_base_i),
      .jump_shift_i    (jump_shift_i),
      .branch_off_i    (branch_off_i),
      .jr_addr_i       (jr_addr_i),
      .target_o        (w_target),
      .valid_o         (w_valid),
      .misalign_o      (w_misalign)
   );

   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_pend_next     = r_pend;
      w_flush_next    = 1'b0;
      w_cnt_inc       = 1'b0;
      w_misalign_next = r_misalign;
      case (r_state)
         ST_RUN: begin
            if (w_valid && w_misalign)
               w_misalign_next = 1'b1;
            if (!stall_i) begin
               if (w_valid) begin
                  w_pc_next    = w_target;
                  w_flush_next = 1'b1;
                  w_cnt_inc    = 1'b1;
               end else begin
                  w_pc_next = r_pc + c_pc_step;
               end
            end else if (w_valid) begin
               w_pend_next  = w_target;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Anything arriving while held is younger wrong-path work; the captured target wins.
            if (!stall_i) begin
               w_pc_next    = r_pend;
               w_flush_next = 1'b1;
               w_cnt_inc    = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= PC_RESET;
         r_pend     <= PC_RESET;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_pend     <= w_pend_next;
         r_flush    <= w_flush_next;
         r_misalign <= w_misalign_next;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         r_cnt <= '0;
      else if (w_cnt_inc && (r_cnt != c_cnt_max))
         r_cnt <= r_cnt + c_cnt_one;
   end

   assign pc_o           = r_pc;
   assign pc_plus4_o     = r_pc + c_pc_step;
   assign flush_o        = r_flush;
   assign misalign_o     = r_misalign;
   assign redirect_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_next_unit                                              |
// | Description : Directed vector table, reset corners and random run against  |
// |               a behavioural next-PC model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_next_unit;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        jr_i = 1'b0;
   logic        jump_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [31:0] redirect_base_i = '0;
   logic [27:0] jump_shift_i = '0;
   logic [31:0] branch_off_i = '0;
   logic [31:0] jr_addr_i = '0;

   logic [31:0] pc_o, pc_plus4_o, pc_s, pc_plus4_s;
   logic        flush_o, misalign_o, flush_s, misalign_s;
   logic [15:0] redirect_cnt_o;
   logic [1:0]  cnt_s;

   always #5 Clk = ~Clk;

   pc_next_unit dut (
      .Clk(Clk), .Rst_n(Rst_n), .stall_i(stall_i), .jr_i(jr_i), .jump_i(jump_i),
      .branch_taken_i(branch_taken_i), .redirect_base_i(redirect_base_i),
      .jump_shift_i(jump_shift_i), .branch_off_i(branch_off_i), .jr_addr_i(jr_addr_i),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .flush_o(flush_o), .misalign_o(misalign_o),
      .redirect_cnt_o(redirect_cnt_o)
   );

   pc_next_unit #(.CNT_W(2)) dut_sat (
      .Clk(Clk), .Rst_n(Rst_n), .stall_i(stall_i), .jr_i(jr_i), .jump_i(jump_i),
      .branch_taken_i(branch_taken_i), .redirect_base_i(redirect_base_i),
      .jump_shift_i(jump_shift_i), .branch_off_i(branch_off_i), .jr_addr_i(jr_addr_i),
      .pc_o(pc_s), .pc_plus4_o(pc_plus4_s), .flush_o(flush_s), .misalign_o(misalign_s),
      .redirect_cnt_o(cnt_s)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: architectural view of the fetch unit.
   logic [31:0] m_pc, m_pend;
   logic        m_hold, m_flush, m_mis;
   int          m_cnt, m_cnt2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pend = 32'h0; m_hold = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic bump();
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      logic        red;
      red = jr_i | jump_i | branch_taken_i;
      if (jr_i) tgt = jr_addr_i;
      else if (jump_i) tgt = {redirect_base_i[31:28], jump_shift_i};
      else tgt = redirect_base_i + branch_off_i;
      m_flush = 1'b0;
      if (!m_hold) begin
         if (red && tgt[1:0] != 2'b00) m_mis = 1'b1;
         if (red && !stall_i) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_flush = 1'b1; bump();
         end else if (red) begin
            m_pend = tgt & 32'hFFFF_FFFC; m_hold = 1'b1;
         end else if (!stall_i) begin
            m_pc = m_pc + 32'd4;
         end
      end else if (!stall_i) begin
         m_pc = m_pend; m_flush = 1'b1; m_hold = 1'b0; bump();
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, " pc"}, pc_o, m_pc);
      chk({tag, " pc+4"}, pc_plus4_o, m_pc + 32'd4);
      chk({tag, " flush"}, {31'd0, flush_o}, {31'd0, m_flush});
      chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, m_mis});
      chk({tag, " cnt"}, {16'd0, redirect_cnt_o}, 32'(m_cnt));
      chk({tag, " cnt_sat"}, {30'd0, cnt_s}, 32'(m_cnt2));
   endtask

   task automatic tick(input string tag);
      @(posedge Clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; jr_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
   endtask

   // Reset asserted mid-cycle, checked before any clock edge, released just after an edge.
   task automatic do_reset();
      #3;
      Rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("reset");
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
   endtask

   typedef struct {
      logic        stall, jr, jump, br;
      logic [31:0] base;
      logic [27:0] jshift;
      logic [31:0] off, jra, exp_pc;
      logic        exp_flush, exp_mis;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic r, input logic j, input logic b,
                               input logic [31:0] base, input logic [27:0] js,
                               input logic [31:0] off, input logic [31:0] jra,
                               input logic [31:0] epc, input logic ef, input logic em);
      vec_t v;
      v.stall = s; v.jr = r; v.jump = j; v.br = b; v.base = base; v.jshift = js;
      v.off = off; v.jra = jra; v.exp_pc = epc; v.exp_flush = ef; v.exp_mis = em;
      return v;
   endfunction

   vec_t vecs[13];

   initial begin
      logic [31:0] rnd;
      vecs[0]  = mk(0,1,0,0, 32'h0,         28'h0,   32'h0,         32'h0040_0010, 32'h0040_0010, 1, 0);
      vecs[1]  = mk(0,0,1,0, 32'h0040_0014, 28'h100, 32'h0,         32'h0,         32'h0000_0100, 1, 0);
      vecs[2]  = mk(0,0,0,0, 32'h0,         28'h0,   32'h0,         32'h0,         32'h0000_0104, 0, 0);
      vecs[3]  = mk(0,1,1,1, 32'h100,       28'h300, 32'h40,        32'h0000_2000, 32'h0000_2000, 1, 0);
      vecs[4]  = mk(1,0,0,1, 32'h100,       28'h0,   32'hFFFF_FFF0, 32'h0,         32'h0000_2000, 0, 0);
      vecs[5]  = mk(1,0,1,0, 32'h100,       28'h500, 32'h0,         32'h0,         32'h0000_2000, 0, 0);
      vecs[6]  = mk(0,0,1,0, 32'h100,       28'h700, 32'h0,         32'h0,         32'h0000_00F0, 1, 0);
      vecs[7]  = mk(0,0,0,0, 32'h0,         28'h0,   32'h0,         32'h0,         32'h0000_00F4, 0, 0);
      vecs[8]  = mk(0,1,0,0, 32'h0,         28'h0,   32'h0,         32'h0000_0103, 32'h0000_0100, 1, 1);
      vecs[9]  = mk(0,0,0,0, 32'h0,         28'h0,   32'h0,         32'h0,         32'h0000_0104, 0, 1);
      vecs[10] = mk(0,1,0,0, 32'h0,         28'h0,   32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1);
      vecs[11] = mk(0,0,0,0, 32'h0,         28'h0,   32'h0,         32'h0,         32'h0000_0000, 0, 1);
      vecs[12] = mk(0,0,0,0, 32'h0,         28'h0,   32'h0,         32'h0,         32'h0000_0004, 0, 1);

      // Power-on reset, then a mid-cycle reset with the bench already running.
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      tick("boot");
      do_reset();
      tick("free1"); chk("free pc 4", pc_o, 32'h4);
      tick("free2"); chk("free pc 8", pc_o, 32'h8);
      tick("free3"); chk("free pc C", pc_o, 32'hC);

      for (int i = 0; i < 13; i++) begin
         stall_i = vecs[i].stall; jr_i = vecs[i].jr; jump_i = vecs[i].jump;
         branch_taken_i = vecs[i].br; redirect_base_i = vecs[i].base;
         jump_shift_i = vecs[i].jshift; branch_off_i = vecs[i].off; jr_addr_i = vecs[i].jra;
         tick($sformatf("vec%0d", i));
         chk($sformatf("vec%0d pc", i), pc_o, vecs[i].exp_pc);
         chk($sformatf("vec%0d flush", i), {31'd0, flush_o}, {31'd0, vecs[i].exp_flush});
         chk($sformatf("vec%0d mis", i), {31'd0, misalign_o}, {31'd0, vecs[i].exp_mis});
         idle_inputs();
      end
      chk("table cnt", {16'd0, redirect_cnt_o}, 32'd6);
      chk("table cnt saturated", {30'd0, cnt_s}, 32'd3);

      // Capture a redirect under stall, then reset while still held.
      stall_i = 1'b1; jr_i = 1'b1; jr_addr_i = 32'h0000_0800;
      tick("hold cap");
      jr_i = 1'b0;
      tick("hold keep");
      stall_i = 1'b0;
      do_reset();
      tick("post-hold1");
      chk("post-hold pc", pc_o, 32'h4);
      chk("post-hold flush", {31'd0, flush_o}, 32'd0);
      tick("post-hold2");
      chk("post-hold pc2", pc_o, 32'h8);
      chk("post-hold flush2", {31'd0, flush_o}, 32'd0);

      // Random traffic: aligned targets first so misalign must stay low, then anything.
      for (int phase = 0; phase < 2; phase++) begin
         for (int i = 0; i < 1500; i++) begin
            stall_i = ($urandom_range(0, 9) < 3);
            jr_i = ($urandom_range(0, 7) == 0);
            jump_i = ($urandom_range(0, 6) == 0);
            branch_taken_i = ($urandom_range(0, 5) == 0);
            redirect_base_i = $urandom;
            rnd = $urandom;
            jump_shift_i = rnd[27:0] & 28'hFFF_FFFC;
            branch_off_i = $urandom & 32'hFFFF_FFFC;
            rnd = $urandom;
            if (rnd[3:0] == 4'h0) jr_addr_i = 32'hFFFF_FFF8;
            else jr_addr_i = rnd;
            if (phase == 0) begin
               redirect_base_i = redirect_base_i & 32'hFFFF_FFFC;
               jr_addr_i = jr_addr_i & 32'hFFFF_FFFC;
            end
            tick($sformatf("rand%0d_%0d", phase, i));
         end
         idle_inputs();
         if (phase == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
